net_packet_arbiter_flattened: RTL and testbench

NET_PACKET_ARBITER_FLATTENED -- requirements
Module: net_packet_arbiter_flattened

---
 rtl/net_packet_arbiter_flattened_pkg.sv | 15 +
 rtl/net_packet_fifo.sv | 51 +++++
 rtl/net_packet_arbiter_flattened.sv | 131 +++++++++++++
 tb/tb_net_packet_arbiter_flattened.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_arbiter_flattened_pkg.sv
// Shared definitions for the flattened network packet arbiter: packet layout,
// overflow-mode encodings and drop counter width.
package net_packet_arbiter_flattened_pkg;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] data;
    } net_packet_t;

    localparam int unsigned NET_PACKET_W      = $bits(net_packet_t);
    localparam int unsigned MODE_BACKPRESSURE = 0;
    localparam int unsigned MODE_DROP         = 1;
    localparam int unsigned DROP_CNT_W        = 16;

endpackage

// File: rtl/net_packet_fifo.sv
// Per-channel packet FIFO; an extra pointer bit separates full from empty.
module net_packet_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] data_i,
    input  logic             pop_i,
    output logic [width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(depth);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [width-1:0] mem_q [depth];
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/net_packet_arbiter_flattened.sv
// Round-robin arbiter merging per-channel packet FIFOs into one registered
// output stream, with backpressure or drop-and-count overflow handling.
module net_packet_arbiter_flattened
    import net_packet_arbiter_flattened_pkg::*;
#(
    parameter int unsigned num_ch_p       = 4,
    parameter int unsigned packet_width_p = NET_PACKET_W,
    parameter int unsigned fifo_depth_p   = 4,
    parameter int unsigned mode_p         = MODE_BACKPRESSURE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [num_ch_p*packet_width_p-1:0]   packets_flat_i,
    input  logic [num_ch_p-1:0]                  valid_i,
    output logic [num_ch_p-1:0]                  ready_o,
    output logic [packet_width_p-1:0]            packet_flat_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [((num_ch_p > 1) ? $clog2(num_ch_p) : 1)-1:0] grant_id_o,
    output logic [DROP_CNT_W-1:0]                drop_count_o
);

    localparam int unsigned ID_W  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
    localparam int unsigned SUM_W = DROP_CNT_W + 1;

    logic [num_ch_p-1:0]       full, empty, push, pop, drop;
    logic [packet_width_p-1:0] fifo_data [num_ch_p];

    logic                      valid_q, valid_d;
    logic [packet_width_p-1:0] packet_q, packet_d;
    logic [ID_W-1:0]           grant_q, grant_d;
    logic [ID_W-1:0]           last_grant_q, last_grant_d;
    logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic                      load_en, found;
    logic [ID_W-1:0]           sel;
    logic [SUM_W-1:0]          drop_sum, drop_total;

    for (genvar k = 0; k < num_ch_p; k++) begin : g_ch
        net_packet_fifo #(
            .width (packet_width_p),
            .depth (fifo_depth_p)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push[k]),
            .data_i  (packets_flat_i[k*packet_width_p +: packet_width_p]),
            .pop_i   (pop[k]),
            .data_o  (fifo_data[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );
    end

    // Input acceptance: full FIFOs either stall the source or discard its packet.
    always_comb begin
        ready_o = '1;
        push    = '0;
        drop    = '0;
        for (int unsigned k = 0; k < num_ch_p; k++) begin
            push[k] = valid_i[k] && !full[k];
            if (mode_p == MODE_DROP) begin
                drop[k] = valid_i[k] && full[k];
            end else begin
                ready_o[k] = reset || !full[k];
            end
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        load_en      = !valid_q || ready_i;
        found        = 1'b0;
        sel          = last_grant_q;
        pop          = '0;
        valid_d      = valid_q;
        packet_d     = packet_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        for (int unsigned i = 1; i <= num_ch_p; i++) begin
            automatic logic [ID_W-1:0] idx = ID_W'((32'(last_grant_q) + i) % num_ch_p);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (load_en) begin
            if (found) begin
                pop[sel]     = 1'b1;
                valid_d      = 1'b1;
                packet_d     = fifo_data[sel];
                grant_d      = sel;
                last_grant_d = sel;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Saturating drop counter; several channels may drop in the same cycle.
    always_comb begin
        drop_sum = '0;
        for (int unsigned k = 0; k < num_ch_p; k++) begin
            drop_sum = drop_sum + SUM_W'(drop[k]);
        end
        drop_total = {1'b0, drop_cnt_q} + drop_sum;
        drop_cnt_d = drop_total[DROP_CNT_W] ? '1 : drop_total[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            packet_q     <= '0;
            grant_q      <= '0;
            last_grant_q <= ID_W'(num_ch_p - 1);
            drop_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            packet_q     <= packet_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign valid_o       = valid_q;
    assign packet_flat_o = packet_q;
    assign grant_id_o    = grant_q;
    assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_net_packet_arbiter_flattened.sv
// Directed bench for the packet arbiter with a per-channel ordering scoreboard.
module tb_net_packet_arbiter_flattened;
    import net_packet_arbiter_flattened_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = NET_PACKET_W;
    localparam int unsigned IDW = 2;

    typedef logic [PW-1:0] pkt_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*PW-1:0] packets_flat_i;
    logic [NCH-1:0]    valid_i, ready_o;
    logic [PW-1:0]     packet_flat_o;
    logic              valid_o, ready_i;
    logic [IDW-1:0]    grant_id_o;
    logic [15:0]       drop_count_o;

    logic [NCH*PW-1:0] m1_packets_flat_i;
    logic [NCH-1:0]    m1_valid_i, m1_ready_o;
    logic [PW-1:0]     m1_packet_flat_o;
    logic              m1_valid_o, m1_ready_i;
    logic [IDW-1:0]    m1_grant_id_o;
    logic [15:0]       m1_drop_count_o;

    int   checks = 0;
    int   failures = 0;
    pkt_t exp_q [NCH][$];
    int   seq [NCH];
    int   acc_cnt [NCH];
    int   gcount [NCH];
    int   delivered;
    logic prev_hold = 1'b0;
    pkt_t prev_pkt;
    logic [IDW-1:0] prev_g;

    always #5 clk = ~clk;

    net_packet_arbiter_flattened #(.num_ch_p(NCH), .packet_width_p(PW), .fifo_depth_p(4), .mode_p(0)) dut (
        .clk(clk), .reset(reset), .packets_flat_i(packets_flat_i), .valid_i(valid_i),
        .ready_o(ready_o), .packet_flat_o(packet_flat_o), .valid_o(valid_o), .ready_i(ready_i),
        .grant_id_o(grant_id_o), .drop_count_o(drop_count_o)
    );

    net_packet_arbiter_flattened #(.num_ch_p(NCH), .packet_width_p(PW), .fifo_depth_p(4), .mode_p(1)) dut_m1 (
        .clk(clk), .reset(reset), .packets_flat_i(m1_packets_flat_i), .valid_i(m1_valid_i),
        .ready_o(m1_ready_o), .packet_flat_o(m1_packet_flat_o), .valid_o(m1_valid_o), .ready_i(m1_ready_i),
        .grant_id_o(m1_grant_id_o), .drop_count_o(m1_drop_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int k);
        packets_flat_i[k*PW +: PW] = {4'(k), 8'(seq[k])};
    endtask

    task automatic drive_tick();
        logic [NCH-1:0] acc;
        acc = valid_i & ready_o;
        tick();
        for (int k = 0; k < NCH; k++) begin
            if (acc[k]) begin
                acc_cnt[k]++;
                seq[k]++;
                set_pkt(k);
            end
        end
    endtask

    task automatic reset_pulse();
        reset      = 1'b1;
        valid_i    = '0;
        m1_valid_i = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        valid_i = '0;
        ready_i = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        for (int k = 0; k < NCH; k++)
            chk($sformatf("drain_empty_ch%0d", k), 32'(exp_q[k].size()), 0);
    endtask

    // Scoreboard: record accepted packets, check delivered ones and held outputs.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) exp_q[k].delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(valid_o), 1);
                chk("hold_packet", 32'(packet_flat_o), 32'(prev_pkt));
                chk("hold_grant", 32'(grant_id_o), 32'(prev_g));
            end
            if (valid_o && ready_i) begin
                chk("out_expected", 32'(exp_q[grant_id_o].size() != 0), 1);
                if (exp_q[grant_id_o].size() != 0)
                    chk("out_order", 32'(packet_flat_o), 32'(exp_q[grant_id_o].pop_front()));
                delivered++;
            end
            for (int k = 0; k < NCH; k++)
                if (valid_i[k] && ready_o[k]) exp_q[k].push_back(packets_flat_i[k*PW +: PW]);
            prev_hold = valid_o && !ready_i;
            prev_pkt  = packet_flat_o;
            prev_g    = grant_id_o;
        end
    end

    initial begin
        int eg, nout, n;
        reset             = 1'b1;
        valid_i           = '0;
        packets_flat_i    = '0;
        ready_i           = 1'b0;
        m1_valid_i        = '0;
        m1_packets_flat_i = '0;
        m1_ready_i        = 1'b0;
        delivered         = 0;
        for (int k = 0; k < NCH; k++) begin
            seq[k] = 1; acc_cnt[k] = 0; gcount[k] = 0;
        end
        tick();
        tick();
        chk("rst_ready_during", 32'(ready_o), 32'hF);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(ready_o), 32'hF);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_packet", 32'(packet_flat_o), 0);
        chk("rst_grant", 32'(grant_id_o), 0);
        chk("rst_drop", 32'(drop_count_o), 0);

        // Single packet latency
        ready_i = 1'b1;
        packets_flat_i[2*PW +: PW] = 12'h0A5;
        valid_i = 4'b0100;
        chk("lat_ready2", 32'(ready_o[2]), 1);
        tick();
        valid_i = '0;
        chk("lat_n_valid", 32'(valid_o), 0);
        tick();
        chk("lat_n1_valid", 32'(valid_o), 1);
        chk("lat_n1_packet", 32'(packet_flat_o), 32'h0A5);
        chk("lat_n1_grant", 32'(grant_id_o), 2);
        tick();
        chk("lat_n2_valid", 32'(valid_o), 0);

        // All channels loaded: strict rotation and fair share
        reset_pulse();
        ready_i = 1'b1;
        for (int k = 0; k < NCH; k++) set_pkt(k);
        valid_i = '1;
        eg = 0;
        nout = 0;
        for (int i = 0; i < 24; i++) begin
            drive_tick();
            if (valid_o) begin
                chk("rr_grant", 32'(grant_id_o), 32'(eg));
                eg = (eg + 1) % NCH;
                if (nout < 16) gcount[grant_id_o]++;
                nout++;
            end
        end
        for (int k = 0; k < NCH; k++) chk($sformatf("rr_share_ch%0d", k), 32'(gcount[k]), 4);
        drain();

        // Backpressure fill of channel 1
        reset_pulse();
        ready_i = 1'b0;
        acc_cnt[1] = 0;
        set_pkt(1);
        valid_i = 4'b0010;
        for (int i = 0; i < 8; i++) drive_tick();
        chk("bp_accepted", 32'(acc_cnt[1]), 5);
        chk("bp_ready_low", 32'(ready_o[1]), 0);
        chk("bp_valid_held", 32'(valid_o), 1);
        valid_i = '0;
        delivered = 0;
        ready_i = 1'b1;
        tick();
        chk("bp_ready_reopen", 32'(ready_o[1]), 1);
        drain();
        chk("bp_delivered", 32'(delivered), 5);
        chk("m0_drop_zero", 32'(drop_count_o), 0);

        // Drop mode, same stimulus
        reset_pulse();
        m1_ready_i = 1'b0;
        m1_valid_i = 4'b0010;
        for (int i = 1; i <= 6; i++) begin
            m1_packets_flat_i[1*PW +: PW] = {4'd1, 8'(i)};
            chk("m1_ready_high", 32'(m1_ready_o[1]), 1);
            tick();
        end
        m1_valid_i = '0;
        tick();
        chk("m1_drop_count", 32'(m1_drop_count_o), 1);
        m1_ready_i = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (m1_valid_o && m1_ready_i) begin
                chk("m1_order", 32'(m1_packet_flat_o), 32'({4'd1, 8'(n + 1)}));
                n++;
            end
            tick();
        end
        chk("m1_delivered", 32'(n), 5);

        // Output stall pattern under load
        reset_pulse();
        for (int k = 0; k < NCH; k++) set_pkt(k);
        valid_i = '1;
        for (int i = 0; i < 24; i++) begin
            ready_i = 1'(i % 2);
            drive_tick();
        end
        drain();

        // Reset with packets in flight
        reset_pulse();
        ready_i = 1'b0;
        set_pkt(0);
        valid_i = 4'b0001;
        for (int i = 0; i < 3; i++) drive_tick();
        valid_i = '0;
        tick();
        chk("mid_buffered_valid", 32'(valid_o), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(valid_o), 0);
        chk("mid_rst_packet", 32'(packet_flat_o), 0);
        tick();
        chk("mid_after_valid", 32'(valid_o), 0);
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_no_stale", 32'(valid_o), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
